// File: rtl/cache_addr_gen_if.sv
// Address bus from the stream generator to the direct-mapped cache.
//   addr_out   : address presented to the cache this cycle
//   addr_valid : addr_out is a new access this cycle (cache is gated on this)
// master = generator side (drives), slave = cache / wrapper side (observes).
interface cache_addr_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] addr_out;
    logic              addr_valid;

    modport master (
        output addr_out,
        output addr_valid
    );

    modport slave (
        input addr_out,
        input addr_valid
    );
endinterface

// File: rtl/cache_addr_gen.sv
// Programmable address-stream generator feeding the direct-mapped cache.
// Produces sequential (+4), strided (+stride), ping-pong (base / base+stride)
// and reverse (-stride) traces, repeated for a programmable number of passes,
// one access per clock with no bubbles across pass boundaries.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_start           : single-cycle run request, honoured only when idle
//   i_mode            : 0 seq, 1 stride, 2 ping-pong, 3 reverse
//   i_base_addr       : first address of every pass
//   i_stride          : byte step for modes 1-3
//   i_length          : accesses per pass
//   i_passes          : number of passes
//   o_cache           : address bus to the cache (addr_out / addr_valid)
//   o_busy            : run in progress
//   o_done            : one-cycle pulse after the last access of a run
//   o_access_count    : accesses issued since the last accepted start, saturating
module cache_addr_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 21,
    parameter int unsigned PASS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [ADDR_W-1:0]     i_stride,
    input  logic [LEN_W-1:0]      i_length,
    input  logic [PASS_W-1:0]     i_passes,
    cache_addr_gen_if.master      o_cache,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_W-1:0]      o_access_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Registered state and latched run configuration
    state_t              r_state;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_stride;
    logic [LEN_W-1:0]    r_len;
    logic [PASS_W-1:0]   r_passes;
    logic [LEN_W-1:0]    r_idx;
    logic [PASS_W-1:0]   r_pass;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic [LEN_W-1:0]    r_count;

    // Next-state values
    state_t              w_state;
    logic [1:0]          w_mode;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_stride;
    logic [LEN_W-1:0]    w_len;
    logic [PASS_W-1:0]   w_passes;
    logic [LEN_W-1:0]    w_idx;
    logic [PASS_W-1:0]   w_pass;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_valid;
    logic                w_busy;
    logic                w_done;
    logic [LEN_W-1:0]    w_count;

    logic                w_last_idx;
    logic                w_last_pass;
    logic [ADDR_W-1:0]   w_step_addr;

    // Position of the access currently on the bus within its pass / run
    assign w_last_idx  = (r_idx == (r_len - LEN_W'(1)));
    assign w_last_pass = (r_pass == (r_passes - PASS_W'(1)));

    // Address following the current one inside a pass; r_addr acts as the
    // running accumulator so no multiplier is needed.
    always_comb begin
        w_step_addr = r_addr;
        case (r_mode)
            2'd0: w_step_addr = r_addr + ADDR_W'(4);
            2'd1: w_step_addr = r_addr + r_stride;
            // Current index even -> next is odd -> base + stride
            2'd2: w_step_addr = r_idx[0] ? r_base : (r_base + r_stride);
            2'd3: w_step_addr = r_addr - r_stride;
            default: w_step_addr = r_addr;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        w_state  = r_state;
        w_mode   = r_mode;
        w_base   = r_base;
        w_stride = r_stride;
        w_len    = r_len;
        w_passes = r_passes;
        w_idx    = r_idx;
        w_pass   = r_pass;
        w_addr   = r_addr;
        w_count  = r_count;
        w_valid  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_mode   = i_mode;
                    w_base   = i_base_addr;
                    w_stride = i_stride;
                    w_len    = i_length;
                    w_passes = i_passes;
                    w_idx    = '0;
                    w_pass   = '0;
                    w_count  = '0;
                    if ((i_length == '0) || (i_passes == '0)) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        // First access goes out the cycle after the accepting edge
                        w_state = S_RUN;
                        w_busy  = 1'b1;
                        w_valid = 1'b1;
                        w_addr  = i_base_addr;
                        w_count = LEN_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (w_last_idx && w_last_pass) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_busy  = 1'b1;
                    w_valid = 1'b1;
                    w_count = (r_count == LEN_MAX) ? r_count : (r_count + LEN_W'(1));
                    if (w_last_idx) begin
                        // Pass boundary: restart the sequence from base
                        w_idx  = '0;
                        w_pass = r_pass + PASS_W'(1);
                        w_addr = r_base;
                    end else begin
                        w_idx  = r_idx + LEN_W'(1);
                        w_addr = w_step_addr;
                    end
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_base   <= '0;
            r_stride <= '0;
            r_len    <= '0;
            r_passes <= '0;
            r_idx    <= '0;
            r_pass   <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state;
            r_mode   <= w_mode;
            r_base   <= w_base;
            r_stride <= w_stride;
            r_len    <= w_len;
            r_passes <= w_passes;
            r_idx    <= w_idx;
            r_pass   <= w_pass;
            r_addr   <= w_addr;
            r_valid  <= w_valid;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_count  <= w_count;
        end
    end

    assign o_cache.addr_out   = r_addr;
    assign o_cache.addr_valid = r_valid;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_access_count     = r_count;

endmodule

// File: tb/tb_cache_addr_gen.sv
// Directed bench for cache_addr_gen. A second, narrow-counter instance
// exercises access-count saturation in a short run.
module tb_cache_addr_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Full-width instance
    logic        i_start;
    logic [1:0]  i_mode;
    logic [31:0] i_base_addr;
    logic [31:0] i_stride;
    logic [20:0] i_length;
    logic [7:0]  i_passes;
    logic        o_busy;
    logic        o_done;
    logic [20:0] o_access_count;

    cache_addr_gen_if #(.ADDR_W(32)) u_bus ();

    cache_addr_gen #(.ADDR_W(32), .LEN_W(21), .PASS_W(8)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_mode         (i_mode),
        .i_base_addr    (i_base_addr),
        .i_stride       (i_stride),
        .i_length       (i_length),
        .i_passes       (i_passes),
        .o_cache        (u_bus),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_access_count (o_access_count)
    );

    // Narrow-counter instance (saturates at 15)
    logic        s_start;
    logic [1:0]  s_mode;
    logic [31:0] s_base_addr;
    logic [31:0] s_stride;
    logic [3:0]  s_length;
    logic [7:0]  s_passes;
    logic        s_busy;
    logic        s_done;
    logic [3:0]  s_access_count;

    cache_addr_gen_if #(.ADDR_W(32)) u_sbus ();

    cache_addr_gen #(.ADDR_W(32), .LEN_W(4), .PASS_W(8)) u_sdut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (s_start),
        .i_mode         (s_mode),
        .i_base_addr    (s_base_addr),
        .i_stride       (s_stride),
        .i_length       (s_length),
        .i_passes       (s_passes),
        .o_cache        (u_sbus),
        .o_busy         (s_busy),
        .o_done         (s_done),
        .o_access_count (s_access_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [31:0] addr, input logic [20:0] cnt);
        chk({tag, "_valid"}, u_bus.addr_valid, 1'b0);
        chk({tag, "_busy"},  o_busy, 1'b0);
        chk({tag, "_done"},  o_done, 1'b0);
        chk({tag, "_addr"},  u_bus.addr_out, addr);
        chk({tag, "_count"}, o_access_count, cnt);
    endtask

    // Start a run and check every access against exp_q, then the done cycle.
    // poke >= 0 raises start again (with different config) during that access.
    task automatic run_check(input string tag, input logic [1:0] m, input logic [31:0] b,
                             input logic [31:0] s, input logic [20:0] len,
                             input logic [7:0] np, input int poke);
        int n;
        n = exp_q.size();
        i_mode      = m;
        i_base_addr = b;
        i_stride    = s;
        i_length    = len;
        i_passes    = np;
        i_start     = 1'b1;
        step();
        i_start     = 1'b0;
        // Config changes after acceptance must have no effect
        i_mode      = ~m;
        i_base_addr = 32'hDEAD_BEEF;
        i_stride    = 32'h1234_5678;
        i_length    = 21'd7;
        i_passes    = 8'd9;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, u_bus.addr_valid, 1'b1);
            chk({tag, "_addr"},  u_bus.addr_out, exp_q[k]);
            chk({tag, "_busy"},  o_busy, 1'b1);
            chk({tag, "_done"},  o_done, 1'b0);
            chk({tag, "_count"}, o_access_count, 64'(k + 1));
            i_start = (k == poke);
            step();
        end
        i_start = 1'b0;
        chk({tag, "_end_done"},  o_done, 1'b1);
        chk({tag, "_end_busy"},  o_busy, 1'b0);
        chk({tag, "_end_valid"}, u_bus.addr_valid, 1'b0);
        chk({tag, "_end_count"}, o_access_count, 64'(n));
        chk({tag, "_end_addr"},  u_bus.addr_out, exp_q[n-1]);
        step();
        chk({tag, "_post_done"}, o_done, 1'b0);
        chk({tag, "_post_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        int  nvalid;
        logic seen_done;

        rst = 1'b1;
        i_start = 1'b0; i_mode = '0; i_base_addr = '0; i_stride = '0; i_length = '0; i_passes = '0;
        s_start = 1'b0; s_mode = '0; s_base_addr = '0; s_stride = '0; s_length = '0; s_passes = '0;
        repeat (3) step();
        chk_idle_outputs("reset", 32'h0, 21'h0);
        rst = 1'b0;
        step();

        // Sequential, single pass
        exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        run_check("seq", 2'd0, 32'h0000_1000, 32'h0, 21'd4, 8'd1, -1);

        // Strided, two passes, back-to-back restart at pass boundary
        exp_q = '{32'h0, 32'h1_0000, 32'h2_0000, 32'h0, 32'h1_0000, 32'h2_0000};
        run_check("stride", 2'd1, 32'h0, 32'h0001_0000, 21'd3, 8'd2, -1);

        // Ping-pong with a stray start during the run
        exp_q = '{32'h40, 32'h1_0040, 32'h40, 32'h1_0040, 32'h40};
        run_check("pingpong", 2'd2, 32'h40, 32'h0001_0000, 21'd5, 8'd1, 1);

        // Reverse with wrap below zero
        exp_q = '{32'h8, 32'h4, 32'h0, 32'hFFFF_FFFC};
        run_check("reverse", 2'd3, 32'h8, 32'h4, 21'd4, 8'd1, -1);

        // Zero-length run: done next cycle, no accesses, address held
        i_mode = 2'd0; i_base_addr = 32'h5000; i_stride = 32'h0; i_length = 21'd0; i_passes = 8'd3;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("zlen_done",  o_done, 1'b1);
        chk("zlen_valid", u_bus.addr_valid, 1'b0);
        chk("zlen_busy",  o_busy, 1'b0);
        chk("zlen_count", o_access_count, 21'd0);
        chk("zlen_addr",  u_bus.addr_out, 32'hFFFF_FFFC);
        step();
        chk_idle_outputs("zlen_post", 32'hFFFF_FFFC, 21'd0);

        // Zero passes behaves the same
        i_length = 21'd4; i_passes = 8'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("zpass_done",  o_done, 1'b1);
        chk("zpass_valid", u_bus.addr_valid, 1'b0);
        step();

        // Mid-run reset abandons the run without a done pulse
        i_mode = 2'd0; i_base_addr = 32'h2000; i_length = 21'd10; i_passes = 8'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("mid_a0", u_bus.addr_out, 32'h2000);
        step();
        chk("mid_a1", u_bus.addr_out, 32'h2004);
        step();
        chk("mid_a2", u_bus.addr_out, 32'h2008);
        rst = 1'b1;
        step();
        chk_idle_outputs("mid_rst", 32'h0, 21'h0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("mid_nodone",  o_done, 1'b0);
            chk("mid_novalid", u_bus.addr_valid, 1'b0);
            step();
        end
        exp_q = '{32'h3000, 32'h3004, 32'h3008};
        run_check("after_rst", 2'd0, 32'h3000, 32'h0, 21'd3, 8'd1, -1);

        // Counter saturation on the 4-bit instance: 15 x 2 = 30 accesses, count holds at 15
        s_mode = 2'd1; s_base_addr = 32'h0; s_stride = 32'h10; s_length = 4'd15; s_passes = 8'd2;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        nvalid = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (u_sbus.addr_valid) begin
                nvalid++;
                if (nvalid == 15) begin
                    chk("sat_addr15",  u_sbus.addr_out, 32'hE0);
                    chk("sat_count15", s_access_count, 4'hF);
                end
                if (nvalid == 16) begin
                    chk("sat_addr16",  u_sbus.addr_out, 32'h0);
                    chk("sat_count16", s_access_count, 4'hF);
                end
            end
            if (s_done) begin
                seen_done = 1'b1;
                chk("sat_total_valid", 64'(nvalid), 64'd30);
                chk("sat_final_count", s_access_count, 4'hF);
                chk("sat_busy_at_done", s_busy, 1'b0);
            end else begin
                step();
            end
        end
        chk("sat_done_seen", seen_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_addr_gen.md
# cache_addr_gen

Programmable address-stream generator that sits directly upstream of the direct-mapped cache and drives its 32-bit address input with one access per clock. It produces sequential, strided, ping-pong (conflict) and reverse patterns, repeated for a configurable number of passes, so the cache's hit/miss output and hit counter can be exercised with known, reproducible traces.

## Interface
- ADDR_W, 32, address width; must match the cache address input
- LEN_W, 21, width of length and access counter; matches the cache hit-counter width
- PASS_W, 8, width of pass count
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a run; sampled only in IDLE
- mode  input  2  0 sequential (+4), 1 strided (+stride), 2 ping-pong, 3 reverse (-stride)
- base_addr  input  ADDR_W  first address of every pass
- stride  input  ADDR_W  byte step for modes 1–3; ignored in mode 0
- length  input  LEN_W  accesses per pass
- passes  input  PASS_W  number of passes
- addr_out  output  ADDR_W  registered address to cache
- addr_valid  output  1  addr_out is a new access this cycle
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at end of run
- access_count  output  LEN_W  accesses issued since last accepted start, saturating

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch mode, base_addr, stride, length, passes; clear index i, pass p, access_count. If length==0 or passes==0 go to DONE, else RUN.
- RUN: each cycle drive addr_out per mode, addr_valid=1, access_count+1 (saturate at 2^LEN_W−1). Advance i; at i==length−1, i←0, p+1. After the access with i==length−1 and p==passes−1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Address per access (i restarts at 0 every pass, so each pass repeats the identical sequence):
  - mode 0: base_addr + 4·i
  - mode 1: base_addr + stride·i
  - mode 2: base_addr when i even, base_addr + stride when i odd
  - mode 3: base_addr − stride·i
- Arithmetic modulo 2^ADDR_W; wrap-around silent, no flag. Implement with a running accumulator (add/subtract stride each access, reload base_addr at pass start); no multiplier.
- start while busy or in DONE: ignored; latched config unchanged.
- Config input changes during RUN: no effect.
- Outside RUN, addr_out holds last issued value, addr_valid=0. The cache samples every clock, so the integration wrapper gates the cache on addr_valid.

## Timing
- Reset (rst=1 at a rising edge, any state including mid-RUN): state IDLE, addr_out=0, addr_valid=0, busy=0, done=0, access_count=0, i=0, p=0. Any run in progress is abandoned; no done pulse.
- start accepted at edge T: addr_valid=1, addr_out=base_addr, busy=1 from T+1.
- N = length·passes accesses, on consecutive cycles T+1 … T+N, no bubbles, including across pass boundaries.
- done=1 and busy=0 in cycle T+N+1; addr_valid=0 from T+N+1. Earliest next start accepted at edge ending T+N+2 (state IDLE).
- Zero-length run: done=1 in T+1, no addr_valid cycles, access_count stays 0.
- busy high in RUN only; done high in DONE only; never both.
- access_count updates in the same cycle as its addr_valid; value after run = min(N, 2^LEN_W−1).

## Test plan
- Reset then mode 0, base 0x0000_1000, length 4, passes 1, start at T -> addr_out 0x1000, 0x1004, 0x1008, 0x100C on T+1..T+4; done in T+5; access_count 4.
- Mode 1, base 0x0000_0000, stride 0x0001_0000, length 3, passes 2 -> 0x0, 0x10000, 0x20000, 0x0, 0x10000, 0x20000 back-to-back; done in T+7; access_count 6.
- Mode 2, base 0x0000_0040, stride 0x0001_0000, length 5 -> 0x40, 0x10040, 0x40, 0x10040, 0x40 (same cache line index, different tag); start pulsed again at T+2 ignored.
- Mode 3, base 0x0000_0008, stride 4, length 4 -> 0x8, 0x4, 0x0, 0xFFFF_FFFC (wrap); then length 0 start -> done next cycle, no addr_valid.
- Mid-run rst at T+3 of a length-10 run -> next cycle all outputs 0, no done; new start runs normally from base_addr.
- length 2^21−1, passes 2 -> access_count saturates at 0x1F_FFFF; done after exactly 2·(2^21−1) valid cycles.
